// File: rtl/tx_hold_fifo.sv
// tx_hold_fifo
// Transmit-side hold buffer between the TX enqueue logic and the XGMII
// dequeuer/encoder. It stores 64-bit data words together with 8-bit status
// in a single-clock FIFO. It also counts the complete frames held, so the
// dequeuer can wait until a frame's last word is buffered before starting
// it, which avoids a mid-frame underrun on XGMII.
//
// Ports
//   clk_xgmii_tx           XGMII TX clock; all logic runs on the rising edge
//   reset_xgmii_tx         synchronous active-high reset
//   txhfifo_wdata/wstatus  word to enqueue; status [7] SOP, [6] EOP, [5] ERR,
//                          [2:0] valid bytes in the EOP word (0 means 8)
//   txhfifo_wen            write request
//   txhfifo_ren            read (pop) request
//   txhfifo_rdata/rstatus  registered output word, held between reads
//   txhfifo_rempty         occupancy == 0
//   txhfifo_ralmost_empty  occupancy <= ALMOST_EMPTY_THRESH
//   txhfifo_wfull          occupancy == 2^AWIDTH
//   txhfifo_walmost_full   occupancy >= ALMOST_FULL_THRESH
//   txhfifo_frame_avail    at least one EOP word is held
//   txhfifo_ovf            one-cycle pulse: a write was dropped because full
//   txhfifo_udf            one-cycle pulse: a read was ignored because empty
module tx_hold_fifo #(
  parameter int AWIDTH              = 4,
  parameter int ALMOST_FULL_THRESH  = 12,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic        clk_xgmii_tx,
  input  logic        reset_xgmii_tx,
  input  logic [63:0] txhfifo_wdata,
  input  logic [7:0]  txhfifo_wstatus,
  input  logic        txhfifo_wen,
  input  logic        txhfifo_ren,
  output logic [63:0] txhfifo_rdata,
  output logic [7:0]  txhfifo_rstatus,
  output logic        txhfifo_rempty,
  output logic        txhfifo_ralmost_empty,
  output logic        txhfifo_wfull,
  output logic        txhfifo_walmost_full,
  output logic        txhfifo_frame_avail,
  output logic        txhfifo_ovf,
  output logic        txhfifo_udf
);

  localparam int              DEPTH   = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(ALMOST_FULL_THRESH);
  localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(ALMOST_EMPTY_THRESH);
  localparam logic [AWIDTH:0] ONE_C   = (AWIDTH+1)'(1);

  logic [71:0]       mem [DEPTH];
  logic [AWIDTH-1:0] wptr;
  logic [AWIDTH-1:0] rptr;
  logic [AWIDTH:0]   count;
  logic [AWIDTH:0]   count_next;
  logic [AWIDTH:0]   frames;
  logic [AWIDTH:0]   frames_next;
  logic              is_full;
  logic              is_empty;
  logic              wr_ok;
  logic              rd_ok;
  logic              wr_eop;
  logic              rd_eop;

  // Full and empty are judged only on the current occupancy. A write while
  // full is therefore dropped even if a read frees a slot in the same cycle,
  // and a read while empty is ignored even if a write lands in that cycle.
  // The frame counter rises on accepted EOP writes and falls on accepted
  // pops of a stored EOP word, so it tracks the frames held.
  always_comb begin
    is_full     = (count == DEPTH_C);
    is_empty    = (count == '0);
    wr_ok       = txhfifo_wen && !is_full;
    rd_ok       = txhfifo_ren && !is_empty;
    wr_eop      = wr_ok && txhfifo_wstatus[6];
    rd_eop      = rd_ok && mem[rptr][70];
    count_next  = count;
    frames_next = frames;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + ONE_C;
      2'b01:   count_next = count - ONE_C;
      default: count_next = count;
    endcase
    case ({wr_eop, rd_eop})
      2'b10:   frames_next = frames + ONE_C;
      2'b01:   frames_next = frames - ONE_C;
      default: frames_next = frames;
    endcase
  end

  // Storage array. It has no reset: after a reset the pointers and the count
  // are cleared, so stale entries can never be read back.
  always_ff @(posedge clk_xgmii_tx) begin
    if (!reset_xgmii_tx && wr_ok) begin
      mem[wptr] <= {txhfifo_wstatus, txhfifo_wdata};
    end
  end

  // Pointers, occupancy, frame counter, read register and all flags. Each
  // flag is registered from the updated count, so every output reflects the
  // operations of the preceding edge and has no combinational path from the
  // wen/ren inputs. The pointers wrap naturally modulo the depth.
  always_ff @(posedge clk_xgmii_tx) begin
    if (reset_xgmii_tx) begin
      wptr                  <= '0;
      rptr                  <= '0;
      count                 <= '0;
      frames                <= '0;
      txhfifo_rdata         <= '0;
      txhfifo_rstatus       <= '0;
      txhfifo_rempty        <= 1'b1;
      txhfifo_ralmost_empty <= 1'b1;
      txhfifo_wfull         <= 1'b0;
      txhfifo_walmost_full  <= 1'b0;
      txhfifo_frame_avail   <= 1'b0;
      txhfifo_ovf           <= 1'b0;
      txhfifo_udf           <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr            <= rptr + 1'b1;
        txhfifo_rdata   <= mem[rptr][63:0];
        txhfifo_rstatus <= mem[rptr][71:64];
      end
      count                 <= count_next;
      frames                <= frames_next;
      txhfifo_rempty        <= (count_next == '0);
      txhfifo_ralmost_empty <= (count_next <= AE_C);
      txhfifo_wfull         <= (count_next == DEPTH_C);
      txhfifo_walmost_full  <= (count_next >= AF_C);
      txhfifo_frame_avail   <= (frames_next != '0);
      txhfifo_ovf           <= txhfifo_wen && is_full;
      txhfifo_udf           <= txhfifo_ren && is_empty;
    end
  end

endmodule

// File: tb/tb_tx_hold_fifo.sv
// tb_tx_hold_fifo
// Self-checking bench for tx_hold_fifo. A queue-based reference model holds
// the words that should be buffered. On every negative clock edge a compare
// process checks each DUT output against values derived from that queue.
// Directed sequences also pin a few literal values, and a long randomized
// phase follows them.
module tb_tx_hold_fifo;

  logic        clk_xgmii_tx;
  logic        reset_xgmii_tx;
  logic [63:0] txhfifo_wdata;
  logic [7:0]  txhfifo_wstatus;
  logic        txhfifo_wen;
  logic        txhfifo_ren;
  logic [63:0] txhfifo_rdata;
  logic [7:0]  txhfifo_rstatus;
  logic        txhfifo_rempty;
  logic        txhfifo_ralmost_empty;
  logic        txhfifo_wfull;
  logic        txhfifo_walmost_full;
  logic        txhfifo_frame_avail;
  logic        txhfifo_ovf;
  logic        txhfifo_udf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [71:0] model_q [$];
  logic [63:0] exp_rdata;
  logic [7:0]  exp_rstatus;
  logic        exp_ovf;
  logic        exp_udf;
  logic        model_on = 1'b0;

  tx_hold_fifo dut (
    .clk_xgmii_tx          (clk_xgmii_tx),
    .reset_xgmii_tx        (reset_xgmii_tx),
    .txhfifo_wdata         (txhfifo_wdata),
    .txhfifo_wstatus       (txhfifo_wstatus),
    .txhfifo_wen           (txhfifo_wen),
    .txhfifo_ren           (txhfifo_ren),
    .txhfifo_rdata         (txhfifo_rdata),
    .txhfifo_rstatus       (txhfifo_rstatus),
    .txhfifo_rempty        (txhfifo_rempty),
    .txhfifo_ralmost_empty (txhfifo_ralmost_empty),
    .txhfifo_wfull         (txhfifo_wfull),
    .txhfifo_walmost_full  (txhfifo_walmost_full),
    .txhfifo_frame_avail   (txhfifo_frame_avail),
    .txhfifo_ovf           (txhfifo_ovf),
    .txhfifo_udf           (txhfifo_udf)
  );

  // Free-running 10 ns clock.
  initial clk_xgmii_tx = 1'b0;
  always #5 clk_xgmii_tx = ~clk_xgmii_tx;

  // Compare one DUT value against its expected value and keep the tallies.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Number of EOP words currently held by the model.
  function automatic int modelFrames();
    int n = 0;
    foreach (model_q[i]) begin
      if (model_q[i][70]) n++;
    end
    return n;
  endfunction

  // Advance the model by one clock edge, using the occupancy before the edge
  // for the full/empty decisions.
  task automatic modelStep(input logic rst, input logic wen, input logic ren,
                           input logic [71:0] word);
    bit full;
    bit empty;
    if (rst) begin
      model_q.delete();
      exp_rdata   = '0;
      exp_rstatus = '0;
      exp_ovf     = 1'b0;
      exp_udf     = 1'b0;
    end else begin
      full    = (model_q.size() == 16);
      empty   = (model_q.size() == 0);
      exp_ovf = wen && full;
      exp_udf = ren && empty;
      if (ren && !empty) begin
        {exp_rstatus, exp_rdata} = model_q.pop_front();
      end
      if (wen && !full) begin
        model_q.push_back(word);
      end
    end
  endtask

  // Drive one cycle of requests, let the edge happen, update the model and
  // return 1 ns after the edge so the outputs have settled.
  task automatic applyStimulus(input logic wen, input logic ren,
                               input logic [63:0] wdata, input logic [7:0] wstat);
    txhfifo_wen     = wen;
    txhfifo_ren     = ren;
    txhfifo_wdata   = wdata;
    txhfifo_wstatus = wstat;
    @(posedge clk_xgmii_tx);
    modelStep(reset_xgmii_tx, wen, ren, {wstat, wdata});
    #1;
  endtask

  // One reset cycle with active requests, which must be ignored.
  task automatic applyReset();
    reset_xgmii_tx = 1'b1;
    applyStimulus(1'b1, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'h40);
    reset_xgmii_tx = 1'b0;
    txhfifo_wen    = 1'b0;
    txhfifo_ren    = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model, away from the
  // active edge.
  always @(negedge clk_xgmii_tx) begin
    if (model_on) begin
      checkOutput("rdata",         txhfifo_rdata,         exp_rdata);
      checkOutput("rstatus",       64'(txhfifo_rstatus),  64'(exp_rstatus));
      checkOutput("rempty",        64'(txhfifo_rempty),        64'(model_q.size() == 0));
      checkOutput("ralmost_empty", 64'(txhfifo_ralmost_empty), 64'(model_q.size() <= 2));
      checkOutput("wfull",         64'(txhfifo_wfull),         64'(model_q.size() == 16));
      checkOutput("walmost_full",  64'(txhfifo_walmost_full),  64'(model_q.size() >= 12));
      checkOutput("frame_avail",   64'(txhfifo_frame_avail),   64'(modelFrames() != 0));
      checkOutput("ovf",           64'(txhfifo_ovf),      64'(exp_ovf));
      checkOutput("udf",           64'(txhfifo_udf),      64'(exp_udf));
    end
  end

  initial begin
    logic [63:0] d;
    logic [7:0]  s;
    reset_xgmii_tx  = 1'b1;
    txhfifo_wen     = 1'b0;
    txhfifo_ren     = 1'b0;
    txhfifo_wdata   = '0;
    txhfifo_wstatus = '0;
    applyReset();
    applyReset();
    model_on = 1'b1;

    // Reset and idle, then a read pulse on the empty FIFO.
    checkOutput("reset_rempty", 64'(txhfifo_rempty), 64'd1);
    checkOutput("reset_rdata",  txhfifo_rdata,       64'd0);
    checkOutput("reset_wfull",  64'(txhfifo_wfull),  64'd0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, '0, '0);
    checkOutput("idle_udf_pulse", 64'(txhfifo_udf), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("idle_udf_clear", 64'(txhfifo_udf), 64'd0);
    checkOutput("idle_rdata",     txhfifo_rdata,    64'd0);

    // Three-word frame written, then popped.
    applyStimulus(1'b1, 1'b0, 64'h1111_1111_1111_1111, 8'h80);
    applyStimulus(1'b1, 1'b0, 64'h2222_2222_2222_2222, 8'h00);
    checkOutput("frame_avail_before_eop", 64'(txhfifo_frame_avail), 64'd0);
    applyStimulus(1'b1, 1'b0, 64'h3333_3333_3333_3333, 8'h45);
    checkOutput("frame_avail_after_eop", 64'(txhfifo_frame_avail), 64'd1);
    applyStimulus(1'b0, 1'b1, '0, '0);
    checkOutput("frame_rdata0",   txhfifo_rdata,           64'h1111_1111_1111_1111);
    checkOutput("frame_rstatus0", 64'(txhfifo_rstatus),    64'h80);
    applyStimulus(1'b0, 1'b1, '0, '0);
    checkOutput("frame_rdata1",   txhfifo_rdata,           64'h2222_2222_2222_2222);
    applyStimulus(1'b0, 1'b1, '0, '0);
    checkOutput("frame_rdata2",   txhfifo_rdata,           64'h3333_3333_3333_3333);
    checkOutput("frame_rstatus2", 64'(txhfifo_rstatus),    64'h45);
    checkOutput("frame_avail_after_pop", 64'(txhfifo_frame_avail), 64'd0);
    checkOutput("frame_rempty",   64'(txhfifo_rempty),     64'd1);

    // Fill 16 words without EOP, overflow once, then drain.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0, 64'(i) * 64'h0101_0101_0101_0101, 8'h00);
      if (i == 11) checkOutput("fill_almost_full_11", 64'(txhfifo_walmost_full), 64'd0);
      if (i == 12) checkOutput("fill_almost_full_12", 64'(txhfifo_walmost_full), 64'd1);
      if (i == 15) checkOutput("fill_full_15",        64'(txhfifo_wfull),        64'd0);
    end
    checkOutput("fill_full_16", 64'(txhfifo_wfull), 64'd1);
    applyStimulus(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h40);
    checkOutput("fill_ovf",         64'(txhfifo_ovf),         64'd1);
    checkOutput("fill_no_frame",    64'(txhfifo_frame_avail), 64'd0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b1, '0, '0);
    end
    checkOutput("fill_last_rdata", txhfifo_rdata, 64'h1010_1010_1010_1010);
    checkOutput("fill_drained",    64'(txhfifo_rempty), 64'd1);

    // Full with simultaneous write and read: the read wins, the write drops.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, {$urandom, $urandom}, 8'h00);
    end
    applyStimulus(1'b1, 1'b1, 64'hABCD_ABCD_ABCD_ABCD, 8'h40);
    checkOutput("full_both_ovf",   64'(txhfifo_ovf),   64'd1);
    checkOutput("full_both_wfull", 64'(txhfifo_wfull), 64'd0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b1, '0, '0);
    end
    // Empty with simultaneous write and read: the write lands, the read drops.
    applyStimulus(1'b1, 1'b1, 64'h5555_5555_5555_5555, 8'hC8);
    checkOutput("empty_both_udf",    64'(txhfifo_udf),    64'd1);
    checkOutput("empty_both_rempty", 64'(txhfifo_rempty), 64'd0);
    applyStimulus(1'b0, 1'b1, '0, '0);
    checkOutput("empty_both_rdata", txhfifo_rdata, 64'h5555_5555_5555_5555);

    // Streaming: prime to four words, then 40 cycles of write+read.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, {$urandom, $urandom}, 8'($urandom) & 8'hBF);
    end
    for (int i = 0; i < 40; i++) begin
      s = 8'($urandom);
      applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, s);
    end
    while (!txhfifo_rempty && n_checks < 90000) begin
      applyStimulus(1'b0, 1'b1, '0, '0);
    end

    // Randomized traffic with varying read/write bias.
    for (int i = 0; i < 3000; i++) begin
      d = {$urandom, $urandom};
      s = 8'($urandom);
      if (i % 1000 < 500) applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, d, s);
      else                applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, d, s);
    end

    // Reset while six words and one frame are held.
    applyReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 64'(i + 100), (i == 3) ? 8'h40 : 8'h00);
    end
    checkOutput("prereset_frame", 64'(txhfifo_frame_avail), 64'd1);
    applyReset();
    checkOutput("postreset_rempty", 64'(txhfifo_rempty),      64'd1);
    checkOutput("postreset_frame",  64'(txhfifo_frame_avail), 64'd0);
    applyStimulus(1'b1, 1'b0, 64'h7777_0000_7777_0000, 8'h40);
    applyStimulus(1'b0, 1'b1, '0, '0);
    checkOutput("postreset_rdata",  txhfifo_rdata,       64'h7777_0000_7777_0000);
    checkOutput("postreset_empty",  64'(txhfifo_rempty), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, '0);

    @(posedge clk_xgmii_tx);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
